// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register bank: slave address, default index width,
// reset/idle byte values and the out-of-range address helper.
package i2c_pkg;
    localparam logic [6:0] SL_ADDR     = 7'h50;
    localparam int         AW_DEF      = 4;
    localparam logic [7:0] RST_VAL_DEF = 8'h00;
    localparam logic [7:0] XMIT_IDLE   = 8'hFF;

    // An address is out of range when any bit above the register index field is set.
    function automatic logic addr_oor(input logic [6:0] addr, input int aw);
        return (addr >> aw) != 7'd0;
    endfunction
endpackage

// File: rtl/i2c_sync_edge.sv
// SYNC_N-stage synchronizer for a W-bit async input, with a one-clk rising-edge
// pulse derived from bit 0 of the synchronized value.
module i2c_sync_edge #(
    parameter int W      = 1,
    parameter int SYNC_N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_rise
);
    logic [W-1:0] r_stage [SYNC_N];
    logic         r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_N; i++) r_stage[i] <= '0;
            r_prev <= 1'b0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_N; i++) r_stage[i] <= r_stage[i-1];
            r_prev <= r_stage[SYNC_N-1][0];
        end
    end

    assign o_q    = r_stage[SYNC_N-1];
    assign o_rise = o_q[0] & ~r_prev;
endmodule

// File: rtl/i2c_reg_bank.sv
// System-clock register bank behind the I2C slave controller: synchronizes controller
// outputs, writes bytes through an auto-incrementing pointer and serves the read byte.
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int         AW      = AW_DEF,
    parameter int         RO_BASE = 8,
    parameter int         SYNC_N  = 2,
    parameter logic [7:0] RST_VAL = RST_VAL_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    i_i2c_addr,
    input  logic [7:0]                    i_i2c_data,
    input  logic                          i_i2c_dval,
    input  logic                          i_i2c_start,
    input  logic [8*((1<<AW)-RO_BASE)-1:0] i_hw_status,
    output logic [7:0]                    o_xmit_data,
    output logic [8*RO_BASE-1:0]          o_ctrl_regs,
    output logic                          o_wr_pulse,
    output logic [AW-1:0]                 o_wr_index,
    output logic                          o_wr_err
);
    localparam int          NREG   = 1 << AW;
    localparam logic [AW:0] RO_IDX = (AW+1)'(RO_BASE);

    logic [6:0]    w_addr_s;
    logic [7:0]    w_data_s;
    logic          w_wr_stb;
    logic          w_st_stb;
    logic          w_unused_dval_s;
    logic          w_unused_start_s;
    logic          w_unused_addr_rise;
    logic          w_unused_data_rise;

    i2c_sync_edge #(.W(7), .SYNC_N(SYNC_N)) u_sync_addr (
        .clk(clk), .rst_n(rst_n), .i_d(i_i2c_addr), .o_q(w_addr_s), .o_rise(w_unused_addr_rise));
    i2c_sync_edge #(.W(8), .SYNC_N(SYNC_N)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .i_d(i_i2c_data), .o_q(w_data_s), .o_rise(w_unused_data_rise));
    i2c_sync_edge #(.W(1), .SYNC_N(SYNC_N)) u_sync_dval (
        .clk(clk), .rst_n(rst_n), .i_d(i_i2c_dval), .o_q(w_unused_dval_s), .o_rise(w_wr_stb));
    i2c_sync_edge #(.W(1), .SYNC_N(SYNC_N)) u_sync_start (
        .clk(clk), .rst_n(rst_n), .i_d(i_i2c_start), .o_q(w_unused_start_s), .o_rise(w_st_stb));

    logic [6:0]    r_addr_prev;
    logic [6:0]    r_addr_q;
    logic          r_first;
    logic [AW-1:0] r_ptr;
    logic          r_wr_pulse;
    logic          r_wr_err;
    logic [AW-1:0] r_wr_index;
    logic [7:0]    r_xmit;

    logic          w_addr_stable;
    logic          w_addr_chg;
    logic          w_oor_q;
    logic          w_drop_oor;
    logic [AW-1:0] w_tgt;
    logic          w_ro;
    logic          w_we;
    logic [7:0]    w_bytes [NREG];
    logic [7:0]    w_rd_byte;

    // addr_q only follows the synced address after two agreeing samples (skew filter).
    assign w_addr_stable = (w_addr_s == r_addr_prev);
    assign w_addr_chg    = w_addr_stable && (w_addr_s != r_addr_q);
    assign w_oor_q       = addr_oor(r_addr_q, AW);
    assign w_drop_oor    = r_first && w_oor_q;
    assign w_tgt         = r_first ? r_addr_q[AW-1:0] : r_ptr;
    assign w_ro          = {1'b0, w_tgt} >= RO_IDX;
    assign w_we          = w_wr_stb && !w_drop_oor && !w_ro;
    assign w_rd_byte     = w_oor_q ? XMIT_IDLE : w_bytes[r_addr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_prev <= '0;
            r_addr_q    <= '0;
            r_first     <= 1'b1;
            r_ptr       <= '0;
            r_wr_pulse  <= 1'b0;
            r_wr_err    <= 1'b0;
            r_wr_index  <= '0;
            r_xmit      <= XMIT_IDLE;
        end else begin
            r_addr_prev <= w_addr_s;
            if (w_addr_stable) r_addr_q <= w_addr_s;
            r_wr_pulse <= w_we;
            r_wr_err   <= w_wr_stb && (w_drop_oor || w_ro);
            if (w_we) r_wr_index <= w_tgt;
            // Read-only targets still advance the pointer; out-of-range ones do not.
            if (w_wr_stb && !w_drop_oor) begin
                r_ptr   <= w_tgt + 1'b1;
                r_first <= 1'b0;
            end
            // A start or address change re-arms first after any same-clk write.
            if (w_st_stb || w_addr_chg) r_first <= 1'b1;
            r_xmit <= w_rd_byte;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RO_BASE; gi++) begin : g_ctrl
            logic [7:0] r_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                r_reg <= RST_VAL;
                else if (w_we && (w_tgt == AW'(gi)))       r_reg <= w_data_s;
            end
            assign o_ctrl_regs[gi*8 +: 8] = r_reg;
            assign w_bytes[gi]            = r_reg;
        end
        for (gi = RO_BASE; gi < NREG; gi++) begin : g_hw
            assign w_bytes[gi] = i_hw_status[(gi-RO_BASE)*8 +: 8];
        end
    endgenerate

    assign o_xmit_data = r_xmit;
    assign o_wr_pulse  = r_wr_pulse;
    assign o_wr_index  = r_wr_index;
    assign o_wr_err    = r_wr_err;
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the register bank.
module tb_i2c_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_dval;
    logic        i2c_start;
    logic [63:0] hw_status;
    logic [7:0]  xmit_data;
    logic [63:0] ctrl_regs;
    logic        wr_pulse;
    logic [3:0]  wr_index;
    logic        wr_err;

    i2c_reg_bank dut (
        .clk(clk), .rst_n(rst_n),
        .i_i2c_addr(i2c_addr), .i_i2c_data(i2c_data), .i_i2c_dval(i2c_dval),
        .i_i2c_start(i2c_start), .i_hw_status(hw_status),
        .o_xmit_data(xmit_data), .o_ctrl_regs(ctrl_regs), .o_wr_pulse(wr_pulse),
        .o_wr_index(wr_index), .o_wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ev_cnt = 0;
    int m_events = 0;

    // Reference model state
    logic [7:0] m_mem [8];
    logic [6:0] m_addr;
    logic [3:0] m_ptr;
    bit         m_first;

    always @(negedge clk) if (wr_pulse || wr_err) ev_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] m_packed();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_mem[i];
        return p;
    endfunction

    function automatic logic [7:0] m_xmit();
        logic [63:0] sh;
        if (m_addr >= 7'd16) return 8'hFF;
        if (m_addr < 7'd8) return m_mem[m_addr[2:0]];
        sh = hw_status >> ((int'(m_addr) - 8) * 8);
        return sh[7:0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_ptr   = 4'd0;
        m_first = 1'b1;
    endtask

    task automatic set_addr(input logic [6:0] a);
        i2c_addr = a;
        cyc(8);
        if (a != m_addr) m_first = 1'b1;
        m_addr = a;
        chk("xmit_after_addr", {56'd0, xmit_data}, {56'd0, m_xmit()});
        $display("addr  a=%02h xmit=%02h", a, xmit_data);
    endtask

    task automatic do_start();
        i2c_start = 1'b1;
        cyc(4);
        i2c_start = 1'b0;
        cyc(4);
        m_first = 1'b1;
        $display("start");
    endtask

    task automatic do_write(input logic [7:0] b, input bit with_start);
        bit         oor;
        bit         exp_err;
        bit         seen;
        logic [3:0] tgt;
        oor = m_first && (m_addr >= 7'd16);
        tgt = m_first ? m_addr[3:0] : m_ptr;
        exp_err = oor || (tgt >= 4'd8);
        i2c_data = b;
        cyc(3);
        i2c_dval = 1'b1;
        if (with_start) i2c_start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            cyc(1);
            if (wr_pulse || wr_err) seen = 1'b1;
        end
        chk("wr_event_seen", {63'd0, seen}, 64'd1);
        if (seen) begin
            chk("wr_err", {63'd0, wr_err}, {63'd0, exp_err});
            chk("wr_pulse", {63'd0, wr_pulse}, {63'd0, !exp_err});
            if (!exp_err) chk("wr_index", {60'd0, wr_index}, {60'd0, tgt});
            cyc(1);
            chk("pulse_one_clk", {62'd0, wr_pulse, wr_err}, 64'd0);
        end
        i2c_dval  = 1'b0;
        i2c_start = 1'b0;
        cyc(5);
        if (!oor) begin
            if (!exp_err) m_mem[tgt[2:0]] = b;
            m_ptr   = tgt + 4'd1;
            m_first = 1'b0;
        end
        if (with_start) m_first = 1'b1;
        m_events++;
        chk("ctrl_regs", ctrl_regs, m_packed());
        chk("xmit_after_wr", {56'd0, xmit_data}, {56'd0, m_xmit()});
        $display("write d=%02h st=%0d tgt=%0d err=%0d ctrl=%016h", b, with_start, tgt, exp_err, ctrl_regs);
    endtask

    initial begin
        int op;
        hw_status = {$urandom, $urandom};
        rst_n = 1'b0;
        i2c_addr = 7'h00; i2c_data = 8'h00; i2c_dval = 1'b0; i2c_start = 1'b0;
        m_addr = 7'h00;
        m_reset();
        #25;
        chk("rst_ctrl", ctrl_regs, 64'd0);
        chk("rst_xmit", {56'd0, xmit_data}, 64'hFF);
        chk("rst_pulse", {62'd0, wr_pulse, wr_err}, 64'd0);
        chk("rst_index", {60'd0, wr_index}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc(4);
        $display("reset released xmit=%02h", xmit_data);

        // Sequential write with auto-increment
        set_addr(7'h02);
        do_write(8'hA5, 1'b0);
        do_write(8'h5A, 1'b0);
        set_addr(7'h02);
        // Run into the read-only region, then reload the pointer via start
        set_addr(7'h07);
        do_write(8'h11, 1'b0);
        do_write(8'h22, 1'b0);
        do_write(8'h33, 1'b0);
        do_start();
        set_addr(7'h07);
        do_write(8'h44, 1'b0);
        // Top index is read-only; the pointer wraps to 0
        set_addr(7'h0F);
        do_write(8'h55, 1'b0);
        do_write(8'h66, 1'b0);
        // Out-of-range address
        set_addr(7'h20);
        do_write(8'h77, 1'b0);
        do_write(8'h78, 1'b0);
        do_start();
        do_write(8'h79, 1'b0);
        // Write coinciding with start
        set_addr(7'h03);
        do_write(8'h81, 1'b0);
        do_write(8'h82, 1'b1);
        do_write(8'h83, 1'b0);

        // Reset in the middle of a write
        i2c_data = 8'hEE;
        cyc(3);
        i2c_dval = 1'b1;
        cyc(1);
        rst_n = 1'b0;
        i2c_dval = 1'b0;
        cyc(2);
        chk("midrst_ctrl", ctrl_regs, 64'd0);
        chk("midrst_xmit", {56'd0, xmit_data}, 64'hFF);
        rst_n = 1'b1;
        m_reset();
        cyc(12);
        chk("midrst_no_event", ev_cnt, m_events);
        chk("midrst_ctrl_after", ctrl_regs, 64'd0);
        chk("midrst_xmit_after", {56'd0, xmit_data}, {56'd0, m_xmit()});
        $display("mid-write reset done");

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            if (op < 2)       set_addr(7'($urandom_range(0, 19)));
            else if (op == 2) do_start();
            else if (op == 3) do_write(8'($urandom), 1'b1);
            else              do_write(8'($urandom), 1'b0);
        end

        chk("event_count", ev_cnt, m_events);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
